torpedo_launch_scheduler: RTL and testbench
===========================================

// Module: torpedo_launch_scheduler
// PURPOSE
//  Allocates and sequences launches across TORPEDOS torpedo units. Debounces the fire button once per
//  frame, picks a free slot round-robin, samples the ship sin/cos after the trig pipeline latency,
//  fires a one-hot launch pulse and enforces a frame-based cooldown. Tracks each slot's lifetime
//  (t_dead from the unit, or timeout) and force-kills all slots when the game is inactive.
// PARAMETERS
//  TORPEDOS         4   number of torpedo slots (1..8)
//  TRIG_LAT         2   clk cycles from trig_req to valid sin/cos at the ROM output
//  COOLDOWN_FRAMES  8   vsync pulses between accepted launches (0 = none)
//  MAX_LIFE_FRAMES  90  vsync pulses before a live torpedo is force-killed
// PORTS
//  clk          in   1         system clock
//  resetN       in   1         asynchronous, active-low reset
//  vsync        in   1         1-cycle frame pulse
//  fire         in   1         raw fire button, active high
//  game_active  in   1         low = abort/clear all torpedoes
//  t_dead       in   TORPEDOS  per-slot death pulse from torpedo units
//  trig_req     out  1         1-cycle pulse: latch current angle into trig pipeline
//  launch       out  TORPEDOS  one-hot 1-cycle pulse: slot loads position and sin/cos
//  kill         out  TORPEDOS  1-cycle pulse: slot must stop drawing (timeout/abort)
//  alive        out  TORPEDOS  slot currently flying
//  no_slot      out  1         1-cycle pulse: press dropped, all slots alive
//  busy         out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_ptr=0; all life counters 0; debounce regs 0.
//  Debounce: fire_test set to 1 on vsync, ANDed with fire every other cycle; on vsync fire_deb<=fire_test.
//   press = fire_deb & ~fire_deb_q (registered edge, once per frame). One shot per press; no autofire.
//  FSM IDLE: press & game_active -> if any ~alive: sel = first free slot at/after rr_ptr (wrap),
//   trig_req=1 next cycle, go TRIG_WAIT; else no_slot=1 next cycle, stay IDLE.
//  TRIG_WAIT: count TRIG_LAT cycles; then launch[sel]=1 for exactly one cycle, alive[sel]<=1,
//   life[sel]<=0, rr_ptr<=sel+1 mod TORPEDOS, go COOLDOWN (or IDLE if COOLDOWN_FRAMES=0).
//   Latency: press seen at cycle T -> trig_req at T+1 -> launch at T+1+TRIG_LAT.
//  COOLDOWN: count vsync pulses; at COOLDOWN_FRAMES -> IDLE. Presses during TRIG_WAIT/COOLDOWN dropped
//   (not queued, no no_slot pulse).
//  Lifetime: each alive slot's counter increments on vsync; on reaching MAX_LIFE_FRAMES, kill[i]=1
//   one cycle, alive[i]<=0. t_dead[i] clears alive[i] with no kill pulse; t_dead on non-alive ignored.
//   t_dead and timeout same cycle: alive cleared, kill NOT pulsed (t_dead wins).
//   Launch never targets an alive slot; t_dead[sel] during TRIG_WAIT ignored (slot not yet alive).
//  Abort: game_active low -> FSM->IDLE next cycle (pending launch cancelled, no launch pulse),
//   kill pulsed for every alive slot, alive<=0; stays cleared while low; presses ignored.
//  Widths: life counters $clog2(MAX_LIFE_FRAMES+1); cooldown $clog2(COOLDOWN_FRAMES+1); rr_ptr $clog2(TORPEDOS).
//  Async reset mid-launch: all pulses drop immediately, no launch issued afterwards.
// TESTING
//  1. fire held 2 frames, all free -> trig_req once, launch=4'b0001 exactly TRIG_LAT(2) cycles later.
//  2. 5 presses, COOLDOWN_FRAMES frames apart, no deaths -> launches 0001,0010,0100,1000 then no_slot pulse.
//  3. slot 1 t_dead, rr_ptr=2, slots 0,2,3 alive -> next press launches 0010 (wrap search).
//  4. slot alive 90 vsyncs -> kill pulse on 90th vsync, alive bit 0; t_dead same cycle -> no kill.
//  5. press then game_active=0 during TRIG_WAIT -> no launch, kill=alive mask, busy=0 next cycle.
//  6. fire glitch low within frame / press inside cooldown -> no trig_req, no launch.

Source files
------------

// File: rtl/torpedo_launch_scheduler.sv
// Torpedo slot allocator: debounced fire, round-robin slot pick, trig-latency launch,
// frame cooldown, per-slot lifetime timeout and abort kill.
module torpedo_launch_scheduler #(
  parameter int TORPEDOS        = 4,
  parameter int TRIG_LAT        = 2,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAX_LIFE_FRAMES = 90
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                vsync,
  input  logic                fire,
  input  logic                game_active,
  input  logic [TORPEDOS-1:0] t_dead,
  output logic                trig_req,
  output logic [TORPEDOS-1:0] launch,
  output logic [TORPEDOS-1:0] kill,
  output logic [TORPEDOS-1:0] alive,
  output logic                no_slot,
  output logic                busy
);
  // state     | meaning
  // IDLE      | waiting for a debounced press
  // TRIG_WAIT | trig pipeline filling, launch when it is valid
  // COOLDOWN  | counting frames before the next launch may start
  typedef enum logic [1:0] {IDLE, TRIG_WAIT, COOLDOWN} state_t;

  localparam int PW = (TORPEDOS > 1) ? $clog2(TORPEDOS) : 1;
  localparam int LW = $clog2(MAX_LIFE_FRAMES + 1);
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int TW = (TRIG_LAT > 1) ? $clog2(TRIG_LAT) : 1;
  localparam logic [TORPEDOS-1:0] ONE = TORPEDOS'(1);

  state_t         state;
  logic [TW-1:0]  tcnt;
  logic [CW-1:0]  cd;
  logic [PW-1:0]  sel;
  logic [PW-1:0]  rr_ptr;
  logic [LW-1:0]  life [TORPEDOS];
  logic           fire_test, fire_deb, fire_deb_q, phase;
  logic           press, launch_now, any_free;
  logic [PW-1:0]  sel_next;

  // fire is sampled every other cycle and must stay high for the whole frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_test  <= 1'b0;
      fire_deb   <= 1'b0;
      fire_deb_q <= 1'b0;
      phase      <= 1'b0;
    end else begin
      phase      <= ~phase;
      fire_deb_q <= fire_deb;
      if (vsync) begin
        fire_test <= 1'b1;
        fire_deb  <= fire_test;
      end else if (phase) begin
        fire_test <= fire_test & fire;
      end
    end
  end

  assign press      = fire_deb & ~fire_deb_q;
  assign launch_now = (state == TRIG_WAIT) && (tcnt == TW'(TRIG_LAT - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    logic found;
    found    = 1'b0;
    any_free = ~&alive;
    sel_next = rr_ptr;
    for (int k = 0; k < TORPEDOS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= TORPEDOS) idx = idx - TORPEDOS;
      if (!found && !alive[idx]) begin
        found    = 1'b1;
        sel_next = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      tcnt     <= '0;
      cd       <= '0;
      sel      <= '0;
      rr_ptr   <= '0;
      trig_req <= 1'b0;
      launch   <= '0;
      kill     <= '0;
      alive    <= '0;
      no_slot  <= 1'b0;
      for (int i = 0; i < TORPEDOS; i++) life[i] <= '0;
    end else begin
      trig_req <= 1'b0;
      launch   <= '0;
      kill     <= '0;
      no_slot  <= 1'b0;
      if (!game_active) begin
        state <= IDLE;
        kill  <= alive;
        alive <= '0;
        for (int i = 0; i < TORPEDOS; i++) life[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              if (any_free) begin
                sel      <= sel_next;
                trig_req <= 1'b1;
                tcnt     <= '0;
                state    <= TRIG_WAIT;
              end else begin
                no_slot <= 1'b1;
              end
            end
          end
          TRIG_WAIT: begin
            if (launch_now) begin
              launch <= ONE << sel;
              rr_ptr <= (sel == PW'(TORPEDOS - 1)) ? '0 : sel + 1'b1;
              cd     <= '0;
              state  <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          COOLDOWN: begin
            if (vsync) begin
              if (cd == CW'(COOLDOWN_FRAMES - 1)) state <= IDLE;
              else cd <= cd + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
        // a death report in the same cycle as the timeout suppresses the kill
        for (int i = 0; i < TORPEDOS; i++) begin
          if (launch_now && sel == PW'(i)) begin
            alive[i] <= 1'b1;
            life[i]  <= '0;
          end else if (alive[i]) begin
            if (t_dead[i]) begin
              alive[i] <= 1'b0;
              life[i]  <= '0;
            end else if (vsync) begin
              if (life[i] == LW'(MAX_LIFE_FRAMES - 1)) begin
                kill[i]  <= 1'b1;
                alive[i] <= 1'b0;
                life[i]  <= '0;
              end else begin
                life[i] <= life[i] + 1'b1;
              end
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_torpedo_launch_scheduler.sv
// Frame-level bench: each frame is driven cycle by cycle, outputs are collected and compared
// with a per-frame reference model of the slot allocator.
module tb_torpedo_launch_scheduler;
  localparam int N  = 4;
  localparam int TL = 2;
  localparam int CD = 8;
  localparam int ML = 90;
  localparam int L  = 16;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         vsync = 1'b0;
  logic         fire = 1'b0;
  logic         game_active = 1'b1;
  logic [N-1:0] t_dead = '0;
  logic         trig_req, no_slot, busy;
  logic [N-1:0] launch, kill, alive;

  torpedo_launch_scheduler #(.TORPEDOS(N), .TRIG_LAT(TL), .COOLDOWN_FRAMES(CD),
                             .MAX_LIFE_FRAMES(ML)) dut (
    .clk(clk), .resetN(resetN), .vsync(vsync), .fire(fire), .game_active(game_active),
    .t_dead(t_dead), .trig_req(trig_req), .launch(launch), .kill(kill), .alive(alive),
    .no_slot(no_slot), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int frame_no = 0;

  bit m_alive [N];
  int m_life [N];
  int m_rr, m_cd;
  bit fh1, fh2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s frame=%0d observed=%0h expected=%0h", tag, frame_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 0;
      m_life[i]  = 0;
    end
    m_rr = 0; m_cd = 0; fh1 = 0; fh2 = 0;
  endtask

  task automatic do_reset();
    vsync = 0; fire = 0; game_active = 1; t_dead = '0;
    resetN = 0;
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    model_reset();
  endtask

  function automatic logic [N-1:0] alive_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = m_alive[i];
    return m;
  endfunction

  // abort_k: -1 none, otherwise game_active low from that cycle of the frame onward
  task automatic run_frame(input bit fire_lvl, input bit glitch, input logic [N-1:0] td,
                           input int td_k, input int abort_k);
    int trig_n, trig_at, launch_n, launch_at, ns_n;
    logic [N-1:0] launch_or, kill_or, e_launch, e_kill;
    bit press, found, e_trig, e_ns;
    int sel;
    trig_n = 0; trig_at = 0; launch_n = 0; launch_at = 0; ns_n = 0;
    launch_or = '0; kill_or = '0;
    for (int k = 0; k < L; k++) begin
      vsync       = (k == 0);
      fire        = fire_lvl && !(glitch && k >= 5 && k <= 8);
      game_active = !(abort_k >= 0 && k >= abort_k);
      t_dead      = (k == td_k) ? td : '0;
      @(posedge clk); #1;
      if (trig_req) begin trig_n++; trig_at = k + 1; end
      if (|launch) begin launch_n++; launch_at = k + 1; end
      launch_or |= launch;
      kill_or   |= kill;
      if (no_slot) ns_n++;
    end
    vsync = 0; t_dead = '0;

    press = fh1 && !fh2;
    fh2 = fh1;
    fh1 = fire_lvl && !glitch;
    e_trig = 0; e_ns = 0; e_launch = '0; e_kill = '0;
    if (abort_k == 0) begin
      e_kill = alive_mask();
      for (int i = 0; i < N; i++) begin m_alive[i] = 0; m_life[i] = 0; end
      m_cd = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_alive[i]) begin
          if (td_k == 0 && td[i]) begin
            m_alive[i] = 0; m_life[i] = 0;
          end else begin
            m_life[i]++;
            if (m_life[i] == ML) begin
              e_kill[i] = 1; m_alive[i] = 0; m_life[i] = 0;
            end
          end
        end
      end
      if (m_cd > 0) m_cd--;
      if (press && m_cd == 0) begin
        found = 0; sel = 0;
        for (int j = 0; j < N; j++) begin
          int idx;
          idx = (m_rr + j) % N;
          if (!found && !m_alive[idx]) begin found = 1; sel = idx; end
        end
        if (!found) e_ns = 1;
        else begin
          e_trig = 1;
          if (abort_k < 0 || abort_k >= 4) begin
            e_launch[sel] = 1; m_alive[sel] = 1; m_life[sel] = 0;
            m_rr = (sel + 1) % N; m_cd = CD;
          end
        end
      end
      if (td_k > 0 && (abort_k < 0 || abort_k > td_k))
        for (int i = 0; i < N; i++) if (td[i]) begin m_alive[i] = 0; m_life[i] = 0; end
      if (abort_k > 0) begin
        e_kill |= alive_mask();
        for (int i = 0; i < N; i++) begin m_alive[i] = 0; m_life[i] = 0; end
        m_cd = 0;
      end
    end

    chk("trig_count", trig_n, e_trig);
    chk("launch_mask", launch_or, e_launch);
    chk("launch_pulses", launch_n, (e_launch != 0));
    if (trig_n == 1 && launch_n == 1) chk("launch_latency", launch_at - trig_at, TL);
    chk("kill_mask", kill_or, e_kill);
    chk("no_slot_count", ns_n, e_ns);
    chk("alive", alive, alive_mask());
    chk("busy", busy, (m_cd > 0));
    frame_no++;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) run_frame(0, 0, '0, -1, -1);
  endtask

  task automatic press_once();
    run_frame(1, 0, '0, -1, -1);
  endtask

  initial begin
    int guard;
    int victim;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trig", trig_req, 0);
    chk("rst_launch", launch, 0);
    chk("rst_kill", kill, 0);
    chk("rst_alive", alive, 0);
    chk("rst_no_slot", no_slot, 0);
    chk("rst_busy", busy, 0);
    resetN = 1;
    model_reset();

    // fire held two frames, single launch into slot 0
    idle_frames(2);
    run_frame(1, 0, '0, -1, -1);
    run_frame(1, 0, '0, -1, -1);
    idle_frames(3);
    chk("t1_alive", alive, 4'b0001);

    // five presses a cooldown apart: four launches then no_slot
    do_reset();
    idle_frames(2);
    for (int p = 0; p < 5; p++) begin
      press_once();
      idle_frames(CD - 1);
    end
    idle_frames(2);
    chk("t2_all_alive", alive, 4'b1111);

    // rr_ptr=2 with only slot 1 free: search wraps to slot 1
    run_frame(0, 0, 4'b0011, 8, -1);
    press_once(); idle_frames(CD - 1);
    press_once(); idle_frames(CD - 1);
    run_frame(0, 0, 4'b0010, 8, -1);
    press_once(); idle_frames(CD + 1);

    // lifetime timeout, then a death report on the timeout frame
    guard = 0;
    while (alive_mask() == 4'b1111 && guard < 200) begin idle_frames(1); guard++; end
    chk("t4_timeout_seen", (guard < 200), 1);
    victim = -1;
    guard = 0;
    while (victim < 0 && guard < 200) begin
      for (int i = 0; i < N; i++) if (victim < 0 && m_alive[i] && m_life[i] == ML - 1) victim = i;
      if (victim < 0) begin idle_frames(1); guard++; end
    end
    chk("t4_victim_found", (victim >= 0), 1);
    if (victim >= 0) run_frame(0, 0, 4'(1 << victim), 0, -1);

    // abort during the trig wait
    do_reset();
    idle_frames(2);
    press_once(); idle_frames(CD + 1);
    press_once();
    run_frame(0, 0, '0, -1, 3);
    idle_frames(2);

    // glitched fire and a press inside cooldown
    run_frame(1, 1, '0, -1, -1);
    idle_frames(2);
    press_once(); run_frame(0, 0, '0, -1, -1);
    press_once(); idle_frames(CD);

    // async reset while a launch is pending
    do_reset();
    idle_frames(2);
    press_once();
    vsync = 1; fire = 0; game_active = 1;
    @(posedge clk); #1 vsync = 0;
    @(posedge clk); #1;
    chk("rst_mid_trig_seen", trig_req, 1);
    #2 resetN = 0;
    #1;
    chk("rst_mid_launch", launch, 0);
    chk("rst_mid_trig", trig_req, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk); @(posedge clk);
    #1 resetN = 1;
    model_reset();
    idle_frames(3);

    // randomized frames
    do_reset();
    for (int f = 0; f < 320; f++) begin
      bit fl, gl;
      logic [N-1:0] td;
      int tk, ak;
      fl = ($urandom_range(0, 2) == 0);
      gl = fl && ($urandom_range(0, 9) == 0);
      td = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : '0;
      tk = ($urandom_range(0, 3) == 0) ? 0 : 8;
      case ($urandom_range(0, 39))
        0:       ak = 0;
        1:       ak = 3;
        default: ak = -1;
      endcase
      run_frame(fl, gl, td, tk, ak);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
